// File: rtl/axi_rd_burst_master_pkg.sv
// Shared AXI4 channel widths, encodings and helpers, plus the read burst master's FSM state type.
// Imported by the read master and its bench.
package axi_rd_burst_master_pkg;

    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 128;
    localparam int AXI_STRB_W = AXI_DATA_W / 8;
    localparam int AXI_ID_W   = 4;
    localparam int AXI_LEN_W  = 8;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    // Full-width beats that fit in one 4 KB page; no burst may straddle a page.
    localparam int AXI_4K_BEATS = 4096 / AXI_STRB_W;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA
    } rd_state_e;

    function automatic logic [2:0] axi_size_from_bytes(input int unsigned bytes);
        logic [2:0] size;
        size = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if ((32'd1 << i) == bytes) begin
                size = 3'(i);
            end
        end
        return size;
    endfunction

endpackage

// File: rtl/axi_rd_burst_master.sv
// AXI4 read master: splits one (address, beat count) descriptor into INCR bursts that never
// cross 4 KB, and forwards the returned beats as a zero-latency valid/ready stream.
module axi_rd_burst_master
    import axi_rd_burst_master_pkg::*;
#(
    parameter int MAX_BURST_LEN = 16,
    parameter int RD_ID         = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [31:0]           src_addr,
    input  logic [15:0]           num_beats,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [AXI_ID_W-1:0]   m_arid,
    output logic [AXI_ADDR_W-1:0] m_araddr,
    output logic [AXI_LEN_W-1:0]  m_arlen,
    output logic [2:0]            m_arsize,
    output logic [1:0]            m_arburst,
    output logic                  m_arvalid,
    input  logic                  m_arready,
    input  logic [AXI_ID_W-1:0]   m_rid,
    input  logic [AXI_DATA_W-1:0] m_rdata,
    input  logic [1:0]            m_rresp,
    input  logic                  m_rlast,
    input  logic                  m_rvalid,
    output logic                  m_rready,
    output logic [AXI_DATA_W-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last
);

    rd_state_e state_q, state_d;

    logic [31:0] addr_q;
    logic [15:0] remaining_q;
    logic [8:0]  beat_cnt_q;
    logic        err_q;
    logic        done_q;
    logic        zero_pend_q;

    logic [8:0]  ar_len;
    logic        start_acc;
    logic        r_hs;

    // Burst beats = min(remaining, MAX_BURST_LEN, beats left in the current 4 KB page).
    function automatic logic [8:0] calc_burst_len(input logic [15:0] rem, input logic [7:0] page_beat);
        logic [16:0] len;
        logic [16:0] to_page_end;
        len = {1'b0, rem};
        if (len > 17'(MAX_BURST_LEN)) begin
            len = 17'(MAX_BURST_LEN);
        end
        to_page_end = 17'(AXI_4K_BEATS) - {9'd0, page_beat};
        if (len > to_page_end) begin
            len = to_page_end;
        end
        return len[8:0];
    endfunction

    assign ar_len    = calc_burst_len(remaining_q, addr_q[11:4]);
    assign busy      = (state_q != IDLE) || zero_pend_q;
    assign start_acc = start && !busy;
    assign r_hs      = (state_q == DATA) && m_rvalid && out_ready;

    assign done      = done_q;
    assign err       = err_q;
    assign m_arid    = AXI_ID_W'(RD_ID);
    assign m_araddr  = addr_q;
    assign m_arsize  = axi_size_from_bytes(AXI_STRB_W);
    assign m_arburst = AXI_BURST_INCR;
    assign out_data  = m_rdata;

    // R ids are never compared and the low address bits are forced to a beat boundary.
    logic unused_inputs;
    assign unused_inputs = ^{m_rid, src_addr[3:0]};

    always_comb begin
        state_d   = state_q;
        m_arvalid = 1'b0;
        m_arlen   = '0;
        m_rready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_acc && (num_beats != 16'd0)) begin
                    state_d = ADDR;
                end
            end
            ADDR: begin
                m_arvalid = 1'b1;
                m_arlen   = AXI_LEN_W'(ar_len - 9'd1);
                if (m_arready) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                m_rready  = out_ready;
                out_valid = m_rvalid;
                out_last  = m_rvalid && (remaining_q == 16'd0) && (beat_cnt_q == 9'd1);
                if (r_hs && m_rlast) begin
                    state_d = (remaining_q == 16'd0) ? IDLE : ADDR;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // AR fields come from addr_q/remaining_q, which only move on the AR handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            beat_cnt_q  <= '0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            zero_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            done_q      <= 1'b0;
            zero_pend_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_acc) begin
                        err_q <= 1'b0;
                        if (num_beats == 16'd0) begin
                            done_q      <= 1'b1;
                            zero_pend_q <= 1'b1;
                        end else begin
                            addr_q      <= {src_addr[31:4], 4'b0000};
                            remaining_q <= num_beats;
                        end
                    end
                end
                ADDR: begin
                    if (m_arready) begin
                        addr_q      <= addr_q + {19'd0, ar_len, 4'b0000};
                        remaining_q <= remaining_q - {7'd0, ar_len};
                        beat_cnt_q  <= ar_len;
                    end
                end
                DATA: begin
                    if (r_hs) begin
                        beat_cnt_q <= beat_cnt_q - 9'd1;
                        if (m_rresp != AXI_RESP_OKAY) begin
                            err_q <= 1'b1;
                        end
                        if (m_rlast && (remaining_q == 16'd0)) begin
                            done_q <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_rd_burst_master.sv
// Directed bench for axi_rd_burst_master: an in-bench AXI read slave plus per-scenario tasks
// with hand-computed burst addresses, lengths, beat data and timing.
module tb_axi_rd_burst_master;
    import axi_rd_burst_master_pkg::*;

    logic                  clk;
    logic                  rst;
    logic                  start;
    logic [31:0]           src_addr;
    logic [15:0]           num_beats;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic [AXI_ID_W-1:0]   m_arid;
    logic [AXI_ADDR_W-1:0] m_araddr;
    logic [AXI_LEN_W-1:0]  m_arlen;
    logic [2:0]            m_arsize;
    logic [1:0]            m_arburst;
    logic                  m_arvalid;
    logic                  m_arready;
    logic [AXI_ID_W-1:0]   m_rid;
    logic [AXI_DATA_W-1:0] m_rdata;
    logic [1:0]            m_rresp;
    logic                  m_rlast;
    logic                  m_rvalid;
    logic                  m_rready;
    logic [AXI_DATA_W-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_last;

    axi_rd_burst_master #(.MAX_BURST_LEN(16), .RD_ID(0)) dut (
        .clk(clk), .rst(rst), .start(start), .src_addr(src_addr), .num_beats(num_beats),
        .busy(busy), .done(done), .err(err),
        .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
        .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
        .m_rvalid(m_rvalid), .m_rready(m_rready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Slave model and scenario knobs
    logic        sl_active = 1'b0;
    logic [31:0] sl_addr = '0;
    int          sl_len = 0;
    int          sl_idx = 0;
    int          beat_total = 0;
    int          err_beat = 0;
    int          stall_left = 0;
    logic        ready_rand = 1'b0;
    logic        rvalid_force = 1'b0;

    // Per-descriptor observations
    logic [31:0]  ar_addr_log[$];
    int           ar_len_log[$];
    logic [127:0] out_data_log[$];
    int           last_idx_log[$];
    int           done_cnt, done_cyc, last_beat_cyc, start_cyc, first_arv_cyc;
    int           arvalid_cnt, ar_unstable, rready_bad, b2b_bad, rlast_cyc;
    logic         ar_wait, prev_arvalid, check_err_next;
    logic         err_after_bad, err_at_done, err_post_start, busy_at_done;
    logic [31:0]  ar_prev_addr;
    logic [7:0]   ar_prev_len;

    function automatic logic [127:0] beat_word(input logic [31:0] a);
        return {a, ~a, a ^ 32'h5A5A_5A5A, 32'hC0DE_F00D};
    endfunction

    task automatic clear_logs();
        ar_addr_log.delete(); ar_len_log.delete(); out_data_log.delete(); last_idx_log.delete();
        done_cnt = 0; done_cyc = -1; last_beat_cyc = -1; start_cyc = -10; first_arv_cyc = -1;
        arvalid_cnt = 0; ar_unstable = 0; rready_bad = 0; b2b_bad = 0; rlast_cyc = -1;
        ar_wait = 1'b0; prev_arvalid = 1'b0; check_err_next = 1'b0; beat_total = 0;
        err_after_bad = 1'b0; err_at_done = 1'b0; err_post_start = 1'b1; busy_at_done = 1'b1;
        ar_prev_addr = '0; ar_prev_len = '0;
    endtask

    // Drive inputs at negedge, then observe what the coming posedge will commit.
    task automatic run_cycle(input logic st);
        logic drove_valid;
        @(negedge clk);
        if (rst) sl_active = 1'b0;
        start = st;
        m_arready = (stall_left == 0);
        if (!m_arready && m_arvalid) stall_left--;
        out_ready = ready_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
        drove_valid = sl_active;
        m_rvalid = sl_active || rvalid_force;
        m_rid = '0;
        m_rdata = beat_word(sl_addr + 32'(sl_idx * 16));
        m_rlast = sl_active && (sl_idx == sl_len - 1);
        m_rresp = (sl_active && (beat_total + 1 == err_beat)) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
        #1;
        cyc++;
        if (cyc == start_cyc + 1) err_post_start = err;
        if (check_err_next) begin
            err_after_bad = err;
            check_err_next = 1'b0;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            busy_at_done = busy;
            err_at_done = err;
        end
        if (m_arvalid) begin
            arvalid_cnt++;
            if (first_arv_cyc < 0) first_arv_cyc = cyc;
            if (!prev_arvalid && rlast_cyc >= 0 && cyc != rlast_cyc + 1) b2b_bad++;
            if (ar_wait && (m_araddr !== ar_prev_addr || m_arlen !== ar_prev_len)) ar_unstable++;
            ar_wait = !m_arready;
            ar_prev_addr = m_araddr;
            ar_prev_len = m_arlen;
            if (m_arready) begin
                ar_addr_log.push_back(m_araddr);
                ar_len_log.push_back(int'(m_arlen));
                sl_active = 1'b1;
                sl_addr = m_araddr;
                sl_len = int'(m_arlen) + 1;
                sl_idx = 0;
            end
        end else begin
            ar_wait = 1'b0;
        end
        prev_arvalid = m_arvalid;
        if (drove_valid && (m_rready !== out_ready)) rready_bad++;
        if (drove_valid && m_rready) begin
            beat_total++;
            if (beat_total == err_beat) check_err_next = 1'b1;
            sl_idx++;
            if (m_rlast) begin
                sl_active = 1'b0;
                rlast_cyc = cyc;
            end
        end
        if (out_valid && out_ready) begin
            out_data_log.push_back(out_data);
            if (out_last) last_idx_log.push_back(out_data_log.size());
            last_beat_cyc = cyc;
        end
    endtask

    task automatic run_desc(input string tag, input logic [31:0] a, input logic [15:0] n, input int budget);
        int waited;
        clear_logs();
        src_addr = a;
        num_beats = n;
        run_cycle(1'b1);
        start_cyc = cyc;
        waited = 0;
        while (done_cnt == 0 && waited < budget) begin
            run_cycle(1'b0);
            waited++;
        end
        checks++;
        if (done_cnt == 0) begin
            errors++;
            $display("[TB] FAIL %s_timeout: done=0 after %0d cycles, required 1", tag, budget);
        end
        repeat (3) run_cycle(1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rvalid_force = 1'b1;
        clear_logs();
        repeat (2) run_cycle(1'b0);
        checks += 12;
        if (busy !== 1'b0)      begin errors++; $display("[TB] FAIL rst_busy: got %b want 0", busy); end
        if (done !== 1'b0)      begin errors++; $display("[TB] FAIL rst_done: got %b want 0", done); end
        if (err !== 1'b0)       begin errors++; $display("[TB] FAIL rst_err: got %b want 0", err); end
        if (m_arvalid !== 1'b0) begin errors++; $display("[TB] FAIL rst_arvalid: got %b want 0", m_arvalid); end
        if (m_rready !== 1'b0)  begin errors++; $display("[TB] FAIL rst_rready: got %b want 0", m_rready); end
        if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_out_valid: got %b want 0", out_valid); end
        if (out_last !== 1'b0)  begin errors++; $display("[TB] FAIL rst_out_last: got %b want 0", out_last); end
        if (m_araddr !== 32'h0) begin errors++; $display("[TB] FAIL rst_araddr: got %h want 0", m_araddr); end
        if (m_arlen !== 8'h0)   begin errors++; $display("[TB] FAIL rst_arlen: got %h want 0", m_arlen); end
        if (m_arsize !== 3'b100) begin errors++; $display("[TB] FAIL arsize: got %b want 100", m_arsize); end
        if (m_arburst !== 2'b01) begin errors++; $display("[TB] FAIL arburst: got %b want 01", m_arburst); end
        if (m_arid !== 4'h0)    begin errors++; $display("[TB] FAIL arid: got %h want 0", m_arid); end
        rst = 1'b0;
        rvalid_force = 1'b0;
        run_cycle(1'b0);
    endtask

    task automatic test_multi_burst();
        logic [31:0] exp_addr[3];
        int exp_len[3];
        exp_addr = '{32'h0000_1000, 32'h0000_1100, 32'h0000_1200};
        exp_len = '{15, 15, 7};
        run_desc("multi", 32'h0000_1000, 16'd40, 400);
        checks++;
        if (ar_addr_log.size() != 3) begin errors++; $display("[TB] FAIL multi_ar_count: got %0d want 3", ar_addr_log.size()); end
        for (int i = 0; i < 3 && i < ar_addr_log.size(); i++) begin
            checks += 2;
            if (ar_addr_log[i] !== exp_addr[i]) begin errors++; $display("[TB] FAIL multi_araddr%0d: got %h want %h", i, ar_addr_log[i], exp_addr[i]); end
            if (ar_len_log[i] != exp_len[i]) begin errors++; $display("[TB] FAIL multi_arlen%0d: got %0d want %0d", i, ar_len_log[i], exp_len[i]); end
        end
        checks++;
        if (out_data_log.size() != 40) begin errors++; $display("[TB] FAIL multi_beats: got %0d want 40", out_data_log.size()); end
        for (int k = 0; k < out_data_log.size() && k < 40; k++) begin
            checks++;
            if (out_data_log[k] !== beat_word(32'h0000_1000 + 32'(k * 16))) begin
                errors++; $display("[TB] FAIL multi_data%0d: got %h want %h", k, out_data_log[k], beat_word(32'h0000_1000 + 32'(k * 16)));
            end
        end
        checks += 7;
        if (last_idx_log.size() != 1 || last_idx_log[0] != 40) begin errors++; $display("[TB] FAIL multi_out_last: got %0d marks, want one on beat 40", last_idx_log.size()); end
        if (done_cnt != 1) begin errors++; $display("[TB] FAIL multi_done_count: got %0d want 1", done_cnt); end
        if (first_arv_cyc != start_cyc + 1) begin errors++; $display("[TB] FAIL multi_first_ar: got cycle %0d want %0d", first_arv_cyc, start_cyc + 1); end
        if (done_cyc != last_beat_cyc + 1) begin errors++; $display("[TB] FAIL multi_done_time: got cycle %0d want %0d", done_cyc, last_beat_cyc + 1); end
        if (busy_at_done !== 1'b0) begin errors++; $display("[TB] FAIL multi_busy_at_done: got %b want 0", busy_at_done); end
        if (b2b_bad != 0) begin errors++; $display("[TB] FAIL multi_b2b_ar: got %0d late ARs want 0", b2b_bad); end
        if (err !== 1'b0) begin errors++; $display("[TB] FAIL multi_err: got %b want 0", err); end
    endtask

    task automatic test_4k_boundary();
        run_desc("page", 32'h0000_0FC7, 16'd8, 200);
        checks += 2;
        if (ar_addr_log.size() != 2) begin errors++; $display("[TB] FAIL page_ar_count: got %0d want 2", ar_addr_log.size()); end
        if (out_data_log.size() != 8) begin errors++; $display("[TB] FAIL page_beats: got %0d want 8", out_data_log.size()); end
        if (ar_addr_log.size() == 2) begin
            checks += 4;
            if (ar_addr_log[0] !== 32'h0000_0FC0) begin errors++; $display("[TB] FAIL page_araddr0: got %h want 00000fc0", ar_addr_log[0]); end
            if (ar_len_log[0] != 3) begin errors++; $display("[TB] FAIL page_arlen0: got %0d want 3", ar_len_log[0]); end
            if (ar_addr_log[1] !== 32'h0000_1000) begin errors++; $display("[TB] FAIL page_araddr1: got %h want 00001000", ar_addr_log[1]); end
            if (ar_len_log[1] != 3) begin errors++; $display("[TB] FAIL page_arlen1: got %0d want 3", ar_len_log[1]); end
        end
        for (int k = 0; k < out_data_log.size() && k < 8; k++) begin
            checks++;
            if (out_data_log[k] !== beat_word(32'h0000_0FC0 + 32'(k * 16))) begin
                errors++; $display("[TB] FAIL page_data%0d: got %h want %h", k, out_data_log[k], beat_word(32'h0000_0FC0 + 32'(k * 16)));
            end
        end
    endtask

    task automatic test_zero_length();
        run_desc("zero", 32'h0000_7000, 16'd0, 10);
        checks += 3;
        if (done_cyc != start_cyc + 1) begin errors++; $display("[TB] FAIL zero_done_time: got cycle %0d want %0d", done_cyc, start_cyc + 1); end
        if (done_cnt != 1) begin errors++; $display("[TB] FAIL zero_done_count: got %0d want 1", done_cnt); end
        if (arvalid_cnt != 0) begin errors++; $display("[TB] FAIL zero_arvalid: got %0d cycles want 0", arvalid_cnt); end
    endtask

    task automatic test_slverr();
        err_beat = 3;
        run_desc("slverr", 32'h0000_4000, 16'd6, 200);
        err_beat = 0;
        checks += 3;
        if (err_after_bad !== 1'b1) begin errors++; $display("[TB] FAIL slverr_err_set: got %b want 1", err_after_bad); end
        if (err_at_done !== 1'b1) begin errors++; $display("[TB] FAIL slverr_err_at_done: got %b want 1", err_at_done); end
        if (out_data_log.size() != 6) begin errors++; $display("[TB] FAIL slverr_beats: got %0d want 6", out_data_log.size()); end
        checks++;
        if (out_data_log.size() >= 3 && out_data_log[2] !== beat_word(32'h0000_4020)) begin
            errors++; $display("[TB] FAIL slverr_beat3_data: got %h want %h", out_data_log[2], beat_word(32'h0000_4020));
        end
        run_desc("errclr", 32'h0000_5000, 16'd2, 100);
        checks += 2;
        if (err_post_start !== 1'b0) begin errors++; $display("[TB] FAIL errclr_after_start: got %b want 0", err_post_start); end
        if (err !== 1'b0) begin errors++; $display("[TB] FAIL errclr_final: got %b want 0", err); end
    endtask

    task automatic test_stall_backpressure();
        ready_rand = 1'b1;
        stall_left = 20;
        run_desc("stall", 32'h0000_8000, 16'd20, 800);
        ready_rand = 1'b0;
        stall_left = 0;
        checks += 5;
        if (ar_unstable != 0) begin errors++; $display("[TB] FAIL stall_ar_stable: got %0d changes want 0", ar_unstable); end
        if (rready_bad != 0) begin errors++; $display("[TB] FAIL stall_rready_mirror: got %0d mismatching cycles want 0", rready_bad); end
        if (arvalid_cnt != 22) begin errors++; $display("[TB] FAIL stall_arvalid_cycles: got %0d want 22", arvalid_cnt); end
        if (ar_addr_log.size() != 2) begin errors++; $display("[TB] FAIL stall_ar_count: got %0d want 2", ar_addr_log.size()); end
        if (out_data_log.size() != 20) begin errors++; $display("[TB] FAIL stall_beats: got %0d want 20", out_data_log.size()); end
        for (int k = 0; k < out_data_log.size() && k < 20; k++) begin
            checks++;
            if (out_data_log[k] !== beat_word(32'h0000_8000 + 32'(k * 16))) begin
                errors++; $display("[TB] FAIL stall_data%0d: got %h want %h", k, out_data_log[k], beat_word(32'h0000_8000 + 32'(k * 16)));
            end
        end
    endtask

    task automatic test_reset_mid_transfer();
        int waited;
        clear_logs();
        src_addr = 32'h0000_3000;
        num_beats = 16'd32;
        run_cycle(1'b1);
        waited = 0;
        while (out_data_log.size() < 5 && waited < 100) begin
            run_cycle(1'b0);
            waited++;
        end
        checks++;
        if (out_data_log.size() < 5) begin errors++; $display("[TB] FAIL midrst_reach_data: got %0d beats want 5", out_data_log.size()); end
        rst = 1'b1;
        rvalid_force = 1'b1;
        repeat (2) run_cycle(1'b0);
        checks += 6;
        if (busy !== 1'b0)      begin errors++; $display("[TB] FAIL midrst_busy: got %b want 0", busy); end
        if (m_arvalid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_arvalid: got %b want 0", m_arvalid); end
        if (m_rready !== 1'b0)  begin errors++; $display("[TB] FAIL midrst_rready: got %b want 0", m_rready); end
        if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_out_valid: got %b want 0", out_valid); end
        if (out_last !== 1'b0)  begin errors++; $display("[TB] FAIL midrst_out_last: got %b want 0", out_last); end
        if (m_araddr !== 32'h0) begin errors++; $display("[TB] FAIL midrst_araddr: got %h want 0", m_araddr); end
        rst = 1'b0;
        rvalid_force = 1'b0;
        run_cycle(1'b0);
        run_desc("postrst", 32'h0000_2000, 16'd4, 100);
        checks += 3;
        if (ar_addr_log.size() != 1) begin errors++; $display("[TB] FAIL postrst_ar_count: got %0d want 1", ar_addr_log.size()); end
        if (out_data_log.size() != 4) begin errors++; $display("[TB] FAIL postrst_beats: got %0d want 4", out_data_log.size()); end
        if (last_idx_log.size() != 1 || last_idx_log[0] != 4) begin errors++; $display("[TB] FAIL postrst_out_last: got %0d marks, want one on beat 4", last_idx_log.size()); end
        if (ar_addr_log.size() == 1) begin
            checks += 2;
            if (ar_addr_log[0] !== 32'h0000_2000) begin errors++; $display("[TB] FAIL postrst_araddr: got %h want 00002000", ar_addr_log[0]); end
            if (ar_len_log[0] != 3) begin errors++; $display("[TB] FAIL postrst_arlen: got %0d want 3", ar_len_log[0]); end
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        src_addr = '0;
        num_beats = '0;
        m_arready = 1'b0;
        m_rid = '0;
        m_rdata = '0;
        m_rresp = 2'b00;
        m_rlast = 1'b0;
        m_rvalid = 1'b0;
        out_ready = 1'b1;
        test_reset();
        test_multi_burst();
        test_4k_boundary();
        test_zero_length();
        test_slverr();
        test_stall_backpressure();
        test_reset_mid_transfer();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
